pipe_seq_controller: RTL



---
 rtl/pipe_seq_pkg.sv | 15 +
 rtl/seq_step_counter.sv | 30 +++
 rtl/pipe_seq_controller.sv | 104 ++++++++++
 3 files changed

// File: rtl/pipe_seq_pkg.sv
// Shared types and helpers for the pipelined-datapath step sequencer.
package pipe_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    // Width of the binary step index; a single-step sequencer still needs one bit.
    function automatic int unsigned step_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Modulo-STEPS step counter with synchronous clear, advance enable and last-step flag.
module seq_step_counter
    import pipe_seq_pkg::*;
#(
    parameter int unsigned STEPS = 3,
    parameter int unsigned W     = step_width(STEPS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last
);

    localparam logic [W-1:0] LAST_IDX = W'(STEPS - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + W'(1);
        end
    end

    assign last = (count == LAST_IDX);

endmodule

// File: rtl/pipe_seq_controller.sv
// Step sequencer for multi-cycle datapaths: walks STEPS steps per GO with stall,
// abort, back-to-back continuous mode, DONE pulse and completed-operation counter.
module pipe_seq_controller
    import pipe_seq_pkg::*;
#(
    parameter int unsigned STEPS = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           GO,
    input  logic                           CONT,
    input  logic                           HOLD,
    input  logic                           ABORT,
    output logic                           EN,
    output logic [STEPS-1:0]               STEP_OH,
    output logic [step_width(STEPS)-1:0]   STEP,
    output logic                           BUSY,
    output logic                           DONE,
    output logic [CNT_W-1:0]               OPS
);

    localparam int unsigned SW = step_width(STEPS);

    state_t           state_q;
    logic [SW-1:0]    step_q;
    logic             last_step;
    logic             step_clr;
    logic             step_adv;
    logic             done_q;
    logic [CNT_W-1:0] ops_q;

    seq_step_counter #(
        .STEPS (STEPS),
        .W     (SW)
    ) u_step (
        .clk   (clk),
        .reset (reset),
        .clr   (step_clr),
        .en    (step_adv),
        .count (step_q),
        .last  (last_step)
    );

    // Counter wraps to 0 at the last step, which serves both the return to IDLE
    // and the zero-gap restart in continuous mode.
    always_comb begin
        step_clr = 1'b0;
        step_adv = 1'b0;
        case (state_q)
            IDLE:    step_clr = 1'b1;
            RUN: begin
                if (ABORT)      step_clr = 1'b1;
                else if (!HOLD) step_adv = 1'b1;
            end
            STALL:   step_clr = ABORT;
            default: step_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            ops_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (GO) state_q <= RUN;
                end
                RUN: begin
                    if (ABORT) begin
                        state_q <= IDLE;
                    end else if (HOLD) begin
                        state_q <= STALL;
                    end else if (last_step) begin
                        done_q  <= 1'b1;
                        ops_q   <= ops_q + CNT_W'(1);
                        state_q <= (CONT && GO) ? RUN : IDLE;
                    end
                end
                STALL: begin
                    if (ABORT)      state_q <= IDLE;
                    else if (!HOLD) state_q <= RUN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        EN   = (state_q == RUN);
        BUSY = (state_q == RUN) || (state_q == STALL);
        for (int unsigned i = 0; i < STEPS; i++) begin
            STEP_OH[i] = (state_q == RUN) && (step_q == SW'(i));
        end
    end

    assign STEP = step_q;
    assign DONE = done_q;
    assign OPS  = ops_q;

endmodule
